pwm_dac_subsystem: RTL and testbench

PWM_DAC_SUBSYSTEM -- requirements
Module: pwm_dac_subsystem

---
 rtl/pwm_dac_subsystem.sv | 68 ++++++
 tb/tb_pwm_dac_subsystem.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_subsystem.sv
// Millivolt setpoint to PWM duty converter for an RC-filtered DAC pin.
// Three-stage scale pipeline feeds a double-buffered duty register swapped at period end.
module pwm_dac_subsystem #(
    parameter int PWM_BITS = 10,
    parameter int SCALE_K  = 20337
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load_valid,
    input  logic [15:0]         setpoint_mv,
    output logic                load_ready,
    output logic                pwm_out,
    output logic [PWM_BITS:0]   duty_active,
    output logic                period_tick,
    output logic                sat_flag
);

    localparam logic [15:0]         SAT_MV   = 16'd3300;
    localparam logic [31:0]         K32      = 32'(SCALE_K);
    localparam logic [PWM_BITS:0]   DUTY_MAX = {1'b1, {PWM_BITS{1'b0}}};
    localparam logic [31:0]         PROD_MAX = 32'(DUTY_MAX) << 16;
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE  = PWM_BITS'(1);

    logic [2:0]          vld_pipe;
    logic [15:0]         sat;
    logic [31:0]         prod;
    logic [PWM_BITS:0]   pending_duty;
    logic [PWM_BITS:0]   duty_next;
    logic [PWM_BITS-1:0] cnt;
    logic                accept;

    // The busy window spans the pipeline, so at most one load is ever in flight.
    assign load_ready  = ~|vld_pipe;
    assign accept      = load_valid && load_ready;
    assign period_tick = enable && (cnt == CNT_LAST);
    assign duty_next   = (prod >= PROD_MAX) ? DUTY_MAX : prod[16 +: PWM_BITS+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe     <= '0;
            sat          <= '0;
            prod         <= '0;
            pending_duty <= '0;
            duty_active  <= '0;
            sat_flag     <= 1'b0;
            cnt          <= '0;
            pwm_out      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], accept};
            if (accept) begin
                sat      <= (setpoint_mv > SAT_MV) ? SAT_MV : setpoint_mv;
                sat_flag <= (setpoint_mv > SAT_MV);
            end
            if (vld_pipe[0])
                prod <= 32'(sat) * K32;
            if (vld_pipe[1])
                pending_duty <= duty_next;
            // A same-edge pending write is not seen here; it lands one period later.
            if (period_tick)
                duty_active <= pending_duty;
            cnt     <= enable ? cnt + CNT_ONE : '0;
            pwm_out <= enable && ({1'b0, cnt} < duty_active);
        end
    end

endmodule

// File: tb/tb_pwm_dac_subsystem.sv
// Randomized plus directed bench for pwm_dac_subsystem against a cycle-indexed reference model.
module tb_pwm_dac_subsystem;

    localparam int PB     = 10;
    localparam int PERIOD = 1 << PB;
    localparam int K      = 20337;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          load_valid = 1'b0;
    logic [15:0]   setpoint_mv = '0;
    logic          load_ready;
    logic          pwm_out;
    logic [PB:0]   duty_active;
    logic          period_tick;
    logic          sat_flag;

    int n_checks = 0;
    int n_errors = 0;

    pwm_dac_subsystem #(.PWM_BITS(PB), .SCALE_K(K)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load_valid(load_valid),
        .setpoint_mv(setpoint_mv), .load_ready(load_ready), .pwm_out(pwm_out),
        .duty_active(duty_active), .period_tick(period_tick), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Reference model: absolute edge index plus scheduled pending write.
    int  m_cyc = 0, m_cnt = 0, m_duty = 0, m_pend = 0;
    int  m_busy_until = 0, m_write_at = -1, m_write_val = 0;
    bit  m_pwm = 0, m_flag = 0, m_known = 0;

    function automatic int ref_duty(input int mv);
        longint s, d;
        s = (mv > 3300) ? 3300 : mv;
        d = (s * K) / 65536;
        return (d > PERIOD) ? PERIOD : int'(d);
    endfunction

    function automatic bit m_ready();
        return m_cyc >= m_busy_until;
    endfunction

    function automatic bit m_tick();
        return enable && (m_cnt == PERIOD - 1);
    endfunction

    always @(posedge clk) begin
        bit was_ready;
        was_ready = m_ready();
        m_cyc++;
        if (reset) begin
            m_cnt = 0; m_duty = 0; m_pend = 0; m_pwm = 0; m_flag = 0;
            m_busy_until = 0; m_write_at = -1; m_known = 1;
        end else begin
            m_pwm = enable && (m_cnt < m_duty);
            if (enable && m_cnt == PERIOD - 1) m_duty = m_pend;
            if (m_write_at == m_cyc) m_pend = m_write_val;
            if (load_valid && was_ready) begin
                m_busy_until = m_cyc + 3;
                m_write_at   = m_cyc + 2;
                m_write_val  = ref_duty(int'(setpoint_mv));
                m_flag       = setpoint_mv > 16'd3300;
            end
            m_cnt = enable ? (m_cnt + 1) % PERIOD : 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (m_known) begin
            chk("pwm_out",     32'(pwm_out),     32'(m_pwm));
            chk("duty_active", 32'(duty_active), 32'(m_duty));
            chk("load_ready",  32'(load_ready),  32'(m_ready()));
            chk("sat_flag",    32'(sat_flag),    32'(m_flag));
            chk("period_tick", 32'(period_tick), 32'(m_tick()));
        end
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic load(input int mv);
        int b = 0;
        while (!m_ready() && b < 10) begin cyc(); b++; end
        if (b >= 10) chk("ready_timeout", 0, 1);
        load_valid = 1'b1; setpoint_mv = 16'(mv);
        cyc();
        load_valid = 1'b0;
    endtask

    // Returns at the negedge inside a tick cycle; the following cyc() lands after the swap edge.
    task automatic wait_tick();
        int b = 0;
        do begin cyc(); b++; end while (!m_tick() && b < 3 * PERIOD);
        if (!m_tick()) chk("tick_timeout", 0, 1);
    endtask

    task automatic load_and_apply(input int mv, input int exp_duty, input string tag);
        load(mv);
        run(3);
        wait_tick();
        cyc();
        chk(tag, 32'(duty_active), 32'(exp_duty));
    endtask

    task automatic measure_high(input int exp, input string tag);
        int hi = 0;
        repeat (PERIOD) begin cyc(); hi += int'(pwm_out); end
        chk(tag, 32'(hi), 32'(exp));
    endtask

    initial begin
        int b;
        run(2);
        chk("rst_pwm", 32'(pwm_out), 0);
        chk("rst_duty", 32'(duty_active), 0);
        chk("rst_ready", 32'(load_ready), 1);
        chk("rst_sat", 32'(sat_flag), 0);
        reset = 1'b0;
        enable = 1'b1;

        load_and_apply(1650, 512, "duty_1650");
        measure_high(512, "high_1650");
        load_and_apply(1000, 310, "duty_1000");
        load_and_apply(3300, 1024, "duty_3300");
        measure_high(1024, "high_3300");
        load_and_apply(5000, 1024, "duty_5000");
        chk("sat_5000", 32'(sat_flag), 1);
        load_and_apply(0, 0, "duty_0");
        chk("sat_0", 32'(sat_flag), 0);
        measure_high(0, "high_0");

        // Stage 3 lands exactly on the swap edge; busy-time offers are dropped.
        load_and_apply(3300, 1024, "duty_pre");
        b = 0;
        while (m_cnt != PERIOD - 3 && b < 2 * PERIOD) begin cyc(); b++; end
        load_valid = 1'b1; setpoint_mv = 16'd1000;
        cyc();
        setpoint_mv = 16'd5000;
        run(3);
        load_valid = 1'b0;
        cyc();
        chk("late_old_duty", 32'(duty_active), 1024);
        chk("busy_ignored_sat", 32'(sat_flag), 0);
        wait_tick();
        cyc();
        chk("late_new_duty", 32'(duty_active), 310);

        // Enable drop mid-period, then restore.
        run(200);
        enable = 1'b0;
        cyc();
        chk("dis_pwm", 32'(pwm_out), 0);
        chk("dis_tick", 32'(period_tick), 0);
        run(40);
        enable = 1'b1;
        measure_high(310, "reen_high");

        // Reset mid-period with a load in flight.
        run(100);
        load(2000);
        reset = 1'b1;
        run(2);
        chk("rst2_pwm", 32'(pwm_out), 0);
        chk("rst2_duty", 32'(duty_active), 0);
        chk("rst2_ready", 32'(load_ready), 1);
        chk("rst2_sat", 32'(sat_flag), 0);
        reset = 1'b0;
        wait_tick();
        cyc();
        chk("rst2_lost", 32'(duty_active), 0);

        // Random traffic.
        for (int i = 0; i < 16000; i++) begin
            cyc();
            reset      = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) enable = ~enable;
            load_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: setpoint_mv = 16'd3300;
                1: setpoint_mv = 16'd3301;
                2: setpoint_mv = 16'd0;
                3: setpoint_mv = 16'($urandom_range(0, 65535));
                default: setpoint_mv = 16'($urandom_range(0, 6000));
            endcase
        end
        reset = 1'b0; load_valid = 1'b0;
        run(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
